sisc_mc_ctrl: RTL

Parametrised multicycle control unit for the next-generation SISC core. It replaces the fixed-timing controller with a state machine that stalls on a variable-latency req/ack memory handshake and adds load/store and halt. It also adds a memory-timeout error state and a retired-instruction counter. It drives the same datapath (rf, alu, statreg, pc, br, ir, mux4/mux32) plus a shared instruction/data memory port.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_mem_timer.sv | 29 ++
 rtl/sisc_mc_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC control definitions: opcodes, ALU op codes, FSM state encoding.
// Branch decision helper used by the multicycle controller.
package sisc_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ALUI = 4'h2;
   localparam logic [3:0] OP_BRA  = 4'h4;
   localparam logic [3:0] OP_BRR  = 4'h5;
   localparam logic [3:0] OP_BNE  = 4'h6;
   localparam logic [3:0] OP_BNR  = 4'h7;
   localparam logic [3:0] OP_LOD  = 4'h8;
   localparam logic [3:0] OP_STR  = 4'h9;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_RR   = 2'b01;
   localparam logic [1:0] ALU_RI   = 2'b10;
   localparam logic [1:0] ALU_ADDR = 2'b11;

   typedef enum logic [3:0] {
      S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE,
      S_MEM, S_WRITEBACK, S_HALT, S_ERR
   } state_t;

   // hit = any status bit selected by the mask; BNE/BNR branch on no hit
   function automatic logic br_taken(input logic [3:0] opc, input logic hit);
      case (opc)
         OP_BRA, OP_BRR: br_taken = hit;
         OP_BNE, OP_BNR: br_taken = !hit;
         default:        br_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sisc_mem_timer.sv
// Memory-wait timeout: counts request cycles without ack, flags expiry on the
// TO_CYC-th unacknowledged cycle; an ack in that same cycle suppresses expiry.
module sisc_mem_timer #(
   parameter int TO_CYC = 15,
   parameter int TO_W   = 4
) (
   input  logic clk,
   input  logic rst_f,
   input  logic clear,
   input  logic req,
   input  logic ack,
   output logic expire
);

   logic [TO_W-1:0] r_cnt;

   assign expire = req && !ack && (r_cnt == TO_W'(TO_CYC - 1));

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (req && !ack) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// SISC multicycle controller: fetch/decode/execute/mem/writeback FSM stalling on
// a req/ack memory port, with sticky timeout error and retired-instruction count.
module sisc_mc_ctrl
   import sisc_pkg::*;
#(
   parameter int OPC_W    = 4,
   parameter int STAT_W   = 4,
   parameter int ALU_OP_W = 2,
   parameter int TO_CYC   = 15,
   parameter int TO_W     = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_f,
   input  logic [OPC_W-1:0]    opcode,
   input  logic [STAT_W-1:0]   mm,
   input  logic [STAT_W-1:0]   stat,
   input  logic                mem_ack,
   output logic                rf_we,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                wb_sel,
   output logic                br_sel,
   output logic                pc_sel,
   output logic                pc_write,
   output logic                pc_rst,
   output logic                ir_load,
   output logic                rb_sel,
   output logic                stat_en,
   output logic                mem_req,
   output logic                mem_we,
   output logic                busy,
   output logic                err,
   output logic [CNT_W-1:0]    instr_cnt
);

   state_t           r_state;
   state_t           w_nxt;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic             w_alu, w_br, w_ld, w_st, w_hlt, w_nop, w_mem, w_rel;
   logic             w_taken, w_expire, w_clear, w_retire;

   assign w_alu   = (opcode == OP_ALU) || (opcode == OP_ALUI);
   assign w_br    = (opcode == OP_BRA) || (opcode == OP_BRR) || (opcode == OP_BNE) || (opcode == OP_BNR);
   assign w_rel   = (opcode == OP_BRR) || (opcode == OP_BNR);
   assign w_ld    = (opcode == OP_LOD);
   assign w_st    = (opcode == OP_STR);
   assign w_hlt   = (opcode == OP_HLT);
   assign w_mem   = w_ld || w_st;
   assign w_nop   = !(w_alu || w_br || w_mem || w_hlt);
   assign w_taken = br_taken(opcode, |(mm & stat));

   sisc_mem_timer #(.TO_CYC(TO_CYC), .TO_W(TO_W)) u_timer (
      .clk    (clk),
      .rst_f  (rst_f),
      .clear  (w_clear),
      .req    (mem_req),
      .ack    (mem_ack),
      .expire (w_expire)
   );

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_START0:    w_nxt = S_START1;
         S_START1:    w_nxt = S_FETCH;
         S_FETCH:     if (mem_ack) w_nxt = S_DECODE;
                      else if (w_expire) w_nxt = S_ERR;
         S_DECODE:    if (w_hlt) w_nxt = S_HALT;
                      else if (w_nop) w_nxt = S_FETCH;
                      else w_nxt = S_EXECUTE;
         S_EXECUTE:   if (w_alu) w_nxt = S_WRITEBACK;
                      else if (w_mem) w_nxt = S_MEM;
                      else w_nxt = S_FETCH;
         S_MEM:       if (mem_ack) w_nxt = w_st ? S_FETCH : S_WRITEBACK;
                      else if (w_expire) w_nxt = S_ERR;
         S_WRITEBACK: w_nxt = S_FETCH;
         default:     w_nxt = r_state;
      endcase
   end

   // the timer restarts on every fresh entry to a requesting state
   assign w_clear  = (w_nxt != r_state) && ((w_nxt == S_FETCH) || (w_nxt == S_MEM));
   assign w_retire = ((w_nxt == S_FETCH) &&
                      (r_state inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK})) ||
                     ((w_nxt == S_HALT) && (r_state == S_DECODE));

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_state <= S_START0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt == S_ERR) r_err <= 1'b1;
         if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      alu_op   = '0;
      wb_sel   = 1'b0;
      br_sel   = 1'b0;
      pc_sel   = 1'b0;
      pc_write = 1'b0;
      pc_rst   = 1'b0;
      ir_load  = 1'b0;
      rb_sel   = 1'b0;
      stat_en  = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      case (r_state)
         S_START0, S_START1: pc_rst = 1'b1;
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_load  = mem_ack;
            pc_write = mem_ack;
         end
         S_EXECUTE: begin
            if (w_alu) begin
               alu_op  = (opcode == OP_ALUI) ? ALU_OP_W'(ALU_RI) : ALU_OP_W'(ALU_RR);
               stat_en = 1'b1;
            end else if (w_mem) begin
               alu_op = ALU_OP_W'(ALU_ADDR);
            end else if (w_taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = w_rel;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = w_st;
            rb_sel  = w_st;
         end
         S_WRITEBACK: begin
            rf_we  = 1'b1;
            wb_sel = w_ld;
         end
         default: ;
      endcase
   end

   // held low during reset so every output except pc_rst reads 0
   assign busy      = rst_f && !((r_state == S_HALT) || (r_state == S_ERR));
   assign err       = r_err;
   assign instr_cnt = r_cnt;

endmodule
